// File: rtl/dff_ram_pkg.sv
// Shared types and sizing helpers for the banked flip-flop RAM.
package dff_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int LANE_W_DEFAULT = 9;

  function automatic int lanes(input int width, input int lane_w);
    return width / lane_w;
  endfunction

endpackage

// File: rtl/dff_ram_banked_if.sv
// Request/response bundle between a requester and the banked flop RAM.
interface dff_ram_banked_if #(
  parameter int WIDTH  = 72,
  parameter int DEPTH  = 8,
  parameter int LANE_W = dff_ram_pkg::LANE_W_DEFAULT
);
  localparam int AW    = $clog2(DEPTH);
  localparam int LANES = dff_ram_pkg::lanes(WIDTH, LANE_W);

  logic             req;
  logic             wr;
  logic [AW-1:0]    address;
  logic [LANES-1:0] wmask;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             rvalid;
  logic             busy;

  modport master (
    output req, wr, address, wmask, wdata,
    input  rdata, rvalid, busy
  );

  modport slave (
    input  req, wr, address, wmask, wdata,
    output rdata, rvalid, busy
  );
endinterface

// File: rtl/dff_ram_bank.sv
// One bank of flop storage: lane-masked write on the clock edge, combinational read.
module dff_ram_bank #(
  parameter int WIDTH   = 72,
  parameter int ENTRIES = 4,
  parameter int LANE_W  = 9,
  parameter int LANES   = 8,
  parameter int IDX_W   = 2
) (
  input  logic             clk,
  input  logic             en,
  input  logic             wr,
  input  logic [IDX_W-1:0] idx,
  input  logic [LANES-1:0] mask,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [ENTRIES];
  logic [WIDTH-1:0] mem_d [ENTRIES];

  always_comb begin
    mem_d = mem_q;
    if (en && wr) begin
      for (int l = 0; l < LANES; l++) begin
        if (mask[l]) begin
          mem_d[idx][l*LANE_W +: LANE_W] = wdata[l*LANE_W +: LANE_W];
        end
      end
    end
  end

  // Storage carries no reset; the top-level clear sequencer zeroes it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/dff_ram_banked.sv
// Banked flop RAM: clear sequencer after reset, bank decode, one-hot read mux, registered read port.
module dff_ram_banked
  import dff_ram_pkg::*;
#(
  parameter int WIDTH  = 72,
  parameter int DEPTH  = 8,
  parameter int BANKS  = 2,
  parameter int LANE_W = LANE_W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  dff_ram_banked_if.slave bus
);

  localparam int LANES   = lanes(WIDTH, LANE_W);
  localparam int AW      = $clog2(DEPTH);
  localparam int BW      = $clog2(BANKS);
  localparam int IW      = AW - BW;
  localparam int IDX_W   = (IW > 0) ? IW : 1;
  localparam int ENTRIES = DEPTH / BANKS;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t           state_q, state_d;
  logic [AW-1:0]    clr_cnt_q, clr_cnt_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;

  logic             clearing;
  logic             acc;
  logic             rd_acc;
  logic             wr_eff;
  logic [AW-1:0]    addr_eff;
  logic [AW-1:0]    bank_no;
  logic [IDX_W-1:0] idx;
  logic [LANES-1:0] mask_eff;
  logic [WIDTH-1:0] wdata_eff;
  logic [BANKS-1:0] bank_en;
  logic [WIDTH-1:0] bank_rdata [BANKS];
  logic [WIDTH-1:0] rd_mux;

  // While clearing, the counter owns the array and requests are dropped.
  always_comb begin
    clearing  = (state_q == CLEAR);
    acc       = !clearing && bus.req;
    rd_acc    = acc && !bus.wr;
    addr_eff  = clearing ? clr_cnt_q : bus.address;
    wr_eff    = clearing || bus.wr;
    mask_eff  = clearing ? '1 : bus.wmask;
    wdata_eff = clearing ? '0 : bus.wdata;
    bank_no   = addr_eff >> IW;
    idx       = IDX_W'(addr_eff);
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    assign bank_en[b] = (clearing || acc) && (bank_no == AW'(b));

    dff_ram_bank #(
      .WIDTH  (WIDTH),
      .ENTRIES(ENTRIES),
      .LANE_W (LANE_W),
      .LANES  (LANES),
      .IDX_W  (IDX_W)
    ) u_bank (
      .clk  (clk),
      .en   (bank_en[b]),
      .wr   (wr_eff),
      .idx  (idx),
      .mask (mask_eff),
      .wdata(wdata_eff),
      .rdata(bank_rdata[b])
    );
  end

  always_comb begin
    rd_mux = '0;
    for (int b = 0; b < BANKS; b++) begin
      if (bank_en[b]) begin
        rd_mux |= bank_rdata[b];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST) begin
          state_d   = READY;
          clr_cnt_d = '0;
        end
      end
      READY: begin
        if (rd_acc) begin
          rdata_d  = rd_mux;
          rvalid_d = 1'b1;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign bus.busy   = (state_q == CLEAR);

endmodule

// File: tb/tb_dff_ram_banked.sv
// Directed checks on the default 8x72 two-bank RAM plus a model-checked sweep of BANKS=1 and BANKS=4 at DEPTH=16.
module tb_dff_ram_banked;

  localparam int W  = 72;
  localparam int LW = 9;
  localparam int LN = 8;

  logic clk = 1'b0;
  logic rst0;
  logic rst_s;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  dff_ram_banked_if #(.WIDTH(W), .DEPTH(8),  .LANE_W(LW)) bus0 ();
  dff_ram_banked_if #(.WIDTH(W), .DEPTH(16), .LANE_W(LW)) bus1 ();
  dff_ram_banked_if #(.WIDTH(W), .DEPTH(16), .LANE_W(LW)) bus4 ();

  dff_ram_banked #(.WIDTH(W), .DEPTH(8),  .BANKS(2), .LANE_W(LW)) dut  (.clk(clk), .rst(rst0),  .bus(bus0));
  dff_ram_banked #(.WIDTH(W), .DEPTH(16), .BANKS(1), .LANE_W(LW)) dut1 (.clk(clk), .rst(rst_s), .bus(bus1));
  dff_ram_banked #(.WIDTH(W), .DEPTH(16), .BANKS(4), .LANE_W(LW)) dut4 (.clk(clk), .rst(rst_s), .bus(bus4));

  task automatic drive(input logic req, input logic wr, input logic [2:0] a,
                       input logic [LN-1:0] m, input logic [W-1:0] d);
    bus0.req = req; bus0.wr = wr; bus0.address = a; bus0.wmask = m; bus0.wdata = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'd0, '0, '0);
  endtask

  task automatic write0(input logic [2:0] a, input logic [LN-1:0] m, input logic [W-1:0] d);
    drive(1'b1, 1'b1, a, m, d);
    @(negedge clk);
    idle();
  endtask

  task automatic read0(input logic [2:0] a, output logic [W-1:0] d, output logic v);
    drive(1'b1, 1'b0, a, '0, '0);
    @(negedge clk);
    d = bus0.rdata;
    v = bus0.rvalid;
    idle();
  endtask

  task automatic count_busy(input string name);
    int cnt = 0;
    for (int i = 0; i < 40 && bus0.busy === 1'b1; i++) begin
      cnt++;
      @(negedge clk);
    end
    checks++;
    if (cnt != 8 || bus0.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: busy cycles=%0d busy_now=%b, required 8 cycles then 0", name, cnt, bus0.busy);
    end
  endtask

  task automatic test_reset();
    logic [W-1:0] d;
    logic v;
    idle();
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    checks++;
    if (bus0.busy !== 1'b1 || bus0.rvalid !== 1'b0 || bus0.rdata !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b rvalid=%b rdata=%h, required 1 0 0", bus0.busy, bus0.rvalid, bus0.rdata);
    end
    count_busy("reset_busy_len");
    for (int a = 0; a < 8; a++) begin
      read0(3'(a), d, v);
      checks++;
      if (d !== '0 || v !== 1'b1) begin
        errors++;
        $display("FAIL reset_read_zero a=%0d: rdata=%h rvalid=%b, required 0 1", a, d, v);
      end
    end
    @(negedge clk);
    checks++;
    if (bus0.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL idle_rvalid: rvalid=%b, required 0", bus0.rvalid);
    end
  endtask

  task automatic test_full_write();
    logic [W-1:0] exp, d;
    logic v;
    for (int a = 0; a < 8; a++) begin
      exp = {3'(a), 69'h1A5A5A5A5A5A5A5A5A};
      write0(3'(a), '1, exp);
    end
    for (int a = 0; a < 8; a++) begin
      exp = {3'(a), 69'h1A5A5A5A5A5A5A5A5A};
      d = (a < 4) ? dut.g_bank[0].u_bank.mem_q[a] : dut.g_bank[1].u_bank.mem_q[a-4];
      checks++;
      if (d !== exp) begin
        errors++;
        $display("FAIL bank_placement a=%0d: stored=%h, required %h in bank %0d", a, d, exp, a / 4);
      end
      read0(3'(a), d, v);
      checks++;
      if (d !== exp || v !== 1'b1) begin
        errors++;
        $display("FAIL full_write_read a=%0d: rdata=%h rvalid=%b, required %h 1", a, d, v, exp);
      end
    end
  endtask

  task automatic test_partial_mask();
    logic [W-1:0] exp, d;
    logic v;
    write0(3'd3, '1, '1);
    write0(3'd3, 8'b0000_0101, '0);
    exp = '1;
    exp[8:0]   = '0;
    exp[26:18] = '0;
    read0(3'd3, d, v);
    checks++;
    if (d !== exp || v !== 1'b1) begin
      errors++;
      $display("FAIL partial_mask: rdata=%h rvalid=%b, required %h 1", d, v, exp);
    end
    write0(3'd3, '0, '0);
    read0(3'd3, d, v);
    checks++;
    if (d !== exp) begin
      errors++;
      $display("FAIL zero_mask_noop: rdata=%h, required %h", d, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] x;
    x = 72'h0123456789ABCDEF55;
    write0(3'd5, '1, x);
    checks++;
    if (bus0.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL write_rvalid: rvalid=%b, required 0", bus0.rvalid);
    end
    drive(1'b1, 1'b0, 3'd5, '0, '0);
    @(negedge clk);
    idle();
    checks++;
    if (bus0.rdata !== x || bus0.rvalid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_read: rdata=%h rvalid=%b, required %h 1", bus0.rdata, bus0.rvalid, x);
    end
    @(negedge clk);
    checks++;
    if (bus0.rvalid !== 1'b0 || bus0.rdata !== x) begin
      errors++;
      $display("FAIL b2b_hold: rdata=%h rvalid=%b, required %h 0", bus0.rdata, bus0.rvalid, x);
    end
  endtask

  task automatic test_busy_drop();
    logic [W-1:0] d;
    logic v;
    int rv_seen = 0;
    idle();
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    drive(1'b1, 1'b1, 3'd2, '1, '1);
    @(negedge clk);
    drive(1'b1, 1'b0, 3'd7, '0, '0);
    @(negedge clk);
    if (bus0.rvalid !== 1'b0) rv_seen++;
    drive(1'b1, 1'b1, 3'd0, '1, '1);
    @(negedge clk);
    if (bus0.rvalid !== 1'b0) rv_seen++;
    idle();
    checks++;
    if (rv_seen != 0) begin
      errors++;
      $display("FAIL busy_rvalid: rvalid pulses=%0d, required 0", rv_seen);
    end
    for (int i = 0; i < 40 && bus0.busy === 1'b1; i++) @(negedge clk);
    read0(3'd2, d, v);
    checks++;
    if (d !== '0 || v !== 1'b1) begin
      errors++;
      $display("FAIL busy_drop_a2: rdata=%h rvalid=%b, required 0 1", d, v);
    end
    read0(3'd0, d, v);
    checks++;
    if (d !== '0) begin
      errors++;
      $display("FAIL busy_drop_a0: rdata=%h, required 0", d);
    end
  endtask

  task automatic test_reset_mid_clear();
    idle();
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    repeat (4) @(negedge clk);
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    count_busy("mid_clear_busy_len");
  endtask

  task automatic test_reset_mid_read();
    logic [W-1:0] y, d;
    logic v;
    y = 72'hFEDCBA98765432100F;
    write0(3'd1, '1, y);
    read0(3'd1, d, v);
    checks++;
    if (d !== y) begin
      errors++;
      $display("FAIL pre_rst_read: rdata=%h, required %h", d, y);
    end
    drive(1'b1, 1'b0, 3'd1, '0, '0);
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    idle();
    checks++;
    if (bus0.rvalid !== 1'b0 || bus0.rdata !== '0 || bus0.busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_read: rvalid=%b rdata=%h busy=%b, required 0 0 1", bus0.rvalid, bus0.rdata, bus0.busy);
    end
    count_busy("rst_read_busy_len");
  endtask

  task automatic drive_s(input logic req, input logic wr, input logic [3:0] a,
                         input logic [LN-1:0] m, input logic [W-1:0] d);
    bus1.req = req; bus1.wr = wr; bus1.address = a; bus1.wmask = m; bus1.wdata = d;
    bus4.req = req; bus4.wr = wr; bus4.address = a; bus4.wmask = m; bus4.wdata = d;
  endtask

  task automatic test_sweep();
    logic [W-1:0]  model [16];
    logic [95:0]   r96;
    logic [W-1:0]  d;
    logic [LN-1:0] m;
    logic [3:0]    a;
    logic          wr;
    int            bad = 0;
    for (int i = 0; i < 16; i++) model[i] = '0;
    drive_s(1'b0, 1'b0, '0, '0, '0);
    rst_s = 1'b1;
    @(negedge clk);
    rst_s = 1'b0;
    for (int i = 0; i < 40 && (bus1.busy === 1'b1 || bus4.busy === 1'b1); i++) @(negedge clk);
    checks++;
    if (bus1.busy !== 1'b0 || bus4.busy !== 1'b0) begin
      errors++;
      $display("FAIL sweep_ready: busy1=%b busy4=%b, required 0 0", bus1.busy, bus4.busy);
    end
    for (int n = 0; n < 300; n++) begin
      wr  = 1'($urandom_range(0, 1));
      a   = 4'($urandom_range(0, 15));
      m   = 8'($urandom);
      r96 = {$urandom, $urandom, $urandom};
      d   = r96[W-1:0];
      drive_s(1'b1, wr, a, m, d);
      @(negedge clk);
      if (wr) begin
        for (int l = 0; l < LN; l++) if (m[l]) model[a][l*LW +: LW] = d[l*LW +: LW];
        if (bus1.rvalid !== 1'b0 || bus4.rvalid !== 1'b0) bad++;
      end else begin
        if (bus1.rdata !== model[a] || bus1.rvalid !== 1'b1 ||
            bus4.rdata !== model[a] || bus4.rvalid !== 1'b1) begin
          bad++;
          if (bad < 5)
            $display("FAIL sweep_read op=%0d a=%0d: b1=%h/%b b4=%h/%b, required %h/1",
                     n, a, bus1.rdata, bus1.rvalid, bus4.rdata, bus4.rvalid, model[a]);
        end
      end
    end
    drive_s(1'b0, 1'b0, '0, '0, '0);
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL sweep_model: mismatching ops=%0d, required 0", bad);
    end
  endtask

  initial begin
    rst_s = 1'b1;
    drive_s(1'b0, 1'b0, '0, '0, '0);
    test_reset();
    test_full_write();
    test_partial_mask();
    test_back_to_back();
    test_busy_drop();
    test_reset_mid_clear();
    test_reset_mid_read();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
